// File: rtl/gray_input_debounce_if.sv
// gray_input_debounce_if
//   Bundles the switch input and the debounced outputs of gray_input_debounce.
//   slave  : the debouncer (consumes sw_i, produces the debounced vector and pulses)
//   master : the surrounding logic / bench (drives sw_i, observes the rest)
//   sw_i       raw asynchronous gray-code switches, sw_i[WIDTH-1] = MSB
//   s_o        debounced registered gray code, feeds the decoder
//   upd_o      one-cycle pulse after each commit of s_o
//   gray_err_o one-cycle pulse with upd_o when the commit changed more than one bit
//   settling_o high while a candidate value is being timed
interface gray_input_debounce_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] sw_i;
   logic [WIDTH-1:0] s_o;
   logic             upd_o;
   logic             gray_err_o;
   logic             settling_o;

   modport slave (
      input  sw_i,
      output s_o, upd_o, gray_err_o, settling_o
   );

   modport master (
      output sw_i,
      input  s_o, upd_o, gray_err_o, settling_o
   );
endinterface

// File: rtl/gray_input_debounce.sv
// gray_input_debounce
//   Synchronises a raw gray-code switch vector, debounces the whole vector as one
//   unit and presents a glitch-free registered code on bus.s_o for the downstream
//   gray-to-binary decoder. Every commit pulses upd_o; a commit whose old and new
//   values differ in more than one bit also pulses gray_err_o (the commit still
//   happens).
//   clk    rising-edge system clock
//   rst_n  asynchronous active-low reset
//   bus    gray_input_debounce_if.slave (sw_i in; s_o, upd_o, gray_err_o, settling_o out)
module gray_input_debounce #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   gray_input_debounce_if.slave  bus
);
   localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {STABLE = 1'b0, SETTLE = 1'b1} state_t;

   state_t            state, state_n;
   logic [WIDTH-1:0]  sync1, sync2;
   logic [WIDTH-1:0]  cand, cand_n;
   logic [WIDTH-1:0]  s, s_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic              upd, upd_n;
   logic              err, err_n;

   // True when more than one bit is set, i.e. the transition was not a gray step.
   function automatic logic multi_bit(input logic [WIDTH-1:0] d);
      int n;
      n = 0;
      for (int i = 0; i < WIDTH; i++) n += int'(d[i]);
      return n > 1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         state <= STABLE;
         cand  <= '0;
         s     <= '0;
         cnt   <= '0;
         upd   <= 1'b0;
         err   <= 1'b0;
      end else begin
         sync1 <= bus.sw_i;
         sync2 <= sync1;
         state <= state_n;
         cand  <= cand_n;
         s     <= s_n;
         cnt   <= cnt_n;
         upd   <= upd_n;
         err   <= err_n;
      end
   end

   always_comb begin
      state_n = state;
      cand_n  = cand;
      s_n     = s;
      cnt_n   = cnt;
      upd_n   = 1'b0;
      err_n   = 1'b0;
      case (state)
         STABLE: begin
            if (sync2 != s) begin
               cand_n  = sync2;
               cnt_n   = '0;
               state_n = SETTLE;
            end
         end
         SETTLE: begin
            if (sync2 != cand) begin
               cnt_n = '0;
               if (sync2 == s) begin
                  state_n = STABLE;     // bounced back to the committed value
               end else begin
                  cand_n  = sync2;      // new candidate: restart the window
               end
            end else if (cnt != CNT_MAX) begin
               cnt_n = cnt + 1'b1;
            end else begin
               s_n     = cand;
               upd_n   = 1'b1;
               err_n   = multi_bit(cand ^ s);
               cnt_n   = '0;
               state_n = STABLE;
            end
         end
         default: state_n = STABLE;
      endcase
   end

   assign bus.s_o        = s;
   assign bus.upd_o      = upd;
   assign bus.gray_err_o = err;
   assign bus.settling_o = (state == SETTLE);
endmodule

// File: tb/tb_gray_input_debounce.sv
module tb_gray_input_debounce;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   gray_input_debounce_if #(.WIDTH(4)) bus ();

   gray_input_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge; all sampling happens 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] to_gray(input int i);
      logic [3:0] v;
      v = 4'(i);
      return v ^ (v >> 1);
   endfunction

   function automatic logic [3:0] gray_dec(input logic [3:0] g);
      logic [3:0] b;
      b[3] = g[3];
      for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   task automatic test_reset();
      int upd_seen;
      upd_seen = 0;
      rst_n = 1'b0;
      bus.sw_i = 4'b0000;
      repeat (3) tick();
      n_checks++;
      if (bus.s_o !== 4'b0000 || bus.upd_o !== 1'b0 || bus.gray_err_o !== 1'b0 || bus.settling_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values: s=%b upd=%b err=%b settling=%b, required 0000 0 0 0",
                  bus.s_o, bus.upd_o, bus.gray_err_o, bus.settling_o);
      end
      rst_n = 1'b1;
      repeat (20) begin
         tick();
         if (bus.upd_o !== 1'b0 || bus.settling_o !== 1'b0) upd_seen++;
      end
      n_checks++;
      if (upd_seen != 0) begin
         n_fail++;
         $display("FAIL idle_quiet: %0d cycles with upd/settling high, required 0", upd_seen);
      end
      n_checks++;
      if (bus.s_o !== 4'b0000) begin
         n_fail++;
         $display("FAIL idle_s: s=%b, required 0000", bus.s_o);
      end
   endtask

   task automatic test_single_change();
      bus.sw_i = 4'b0001;
      repeat (3) tick();
      n_checks++;
      if (bus.settling_o !== 1'b1) begin
         n_fail++;
         $display("FAIL single_settling: settling=%b after edge 3, required 1", bus.settling_o);
      end
      repeat (3) tick();
      n_checks++;
      if (bus.s_o !== 4'b0000 || bus.upd_o !== 1'b0) begin
         n_fail++;
         $display("FAIL single_early: s=%b upd=%b after edge 6, required 0000 0", bus.s_o, bus.upd_o);
      end
      tick();
      n_checks++;
      if (bus.s_o !== 4'b0001 || bus.upd_o !== 1'b1 || bus.gray_err_o !== 1'b0 || bus.settling_o !== 1'b0) begin
         n_fail++;
         $display("FAIL single_commit: s=%b upd=%b err=%b settling=%b after edge 7, required 0001 1 0 0",
                  bus.s_o, bus.upd_o, bus.gray_err_o, bus.settling_o);
      end
      tick();
      n_checks++;
      if (bus.upd_o !== 1'b0 || bus.s_o !== 4'b0001) begin
         n_fail++;
         $display("FAIL single_pulse_width: upd=%b s=%b after edge 8, required 0 0001", bus.upd_o, bus.s_o);
      end
      repeat (4) tick();
   endtask

   task automatic test_bounce();
      int upd_seen;
      upd_seen = 0;
      bus.sw_i = 4'b0011;
      repeat (3) begin
         tick();
         if (bus.upd_o !== 1'b0) upd_seen++;
      end
      bus.sw_i = 4'b0001;
      repeat (15) begin
         tick();
         if (bus.upd_o !== 1'b0) upd_seen++;
      end
      n_checks++;
      if (upd_seen != 0 || bus.s_o !== 4'b0001) begin
         n_fail++;
         $display("FAIL bounce_reject: upd cycles=%0d s=%b, required 0 0001", upd_seen, bus.s_o);
      end
      n_checks++;
      if (bus.settling_o !== 1'b0) begin
         n_fail++;
         $display("FAIL bounce_settling: settling=%b, required 0", bus.settling_o);
      end
   endtask

   task automatic test_restart();
      int pulses, err_at_pulse, pulse_edge, bad_s;
      pulses = 0; err_at_pulse = 0; pulse_edge = 0; bad_s = 0;
      bus.sw_i = 4'b0101;
      for (int e = 1; e <= 20; e++) begin
         if (e == 3) bus.sw_i = 4'b0111;
         tick();
         if (bus.s_o === 4'b0101) bad_s++;
         if (bus.upd_o === 1'b1) begin
            pulses++;
            pulse_edge = e;
            if (bus.gray_err_o === 1'b1) err_at_pulse++;
         end
      end
      n_checks++;
      if (pulses != 1 || pulse_edge != 9) begin
         n_fail++;
         $display("FAIL restart_pulse: pulses=%0d at edge %0d, required 1 at edge 9", pulses, pulse_edge);
      end
      n_checks++;
      if (err_at_pulse != 1) begin
         n_fail++;
         $display("FAIL restart_gray_err: err pulses=%0d, required 1", err_at_pulse);
      end
      n_checks++;
      if (bus.s_o !== 4'b0111 || bad_s != 0) begin
         n_fail++;
         $display("FAIL restart_value: s=%b intermediate hits=%0d, required 0111 0", bus.s_o, bad_s);
      end
   endtask

   task automatic test_gray_walk();
      int pulses, errs, wrong;
      pulses = 0; errs = 0; wrong = 0;
      rst_n = 1'b0;
      bus.sw_i = 4'b0000;
      tick();
      rst_n = 1'b1;
      repeat (10) tick();
      for (int i = 1; i < 16; i++) begin
         bus.sw_i = to_gray(i);
         repeat (10) begin
            tick();
            if (bus.upd_o === 1'b1) pulses++;
            if (bus.gray_err_o === 1'b1) errs++;
         end
         if (bus.s_o !== to_gray(i) || gray_dec(bus.s_o) !== 4'(i)) begin
            wrong++;
            $display("FAIL walk_step: step %0d s=%b b=%0d, required %b b=%0d",
                     i, bus.s_o, gray_dec(bus.s_o), to_gray(i), i);
         end
      end
      n_checks++;
      if (wrong != 0) n_fail++;
      n_checks++;
      if (pulses != 15) begin
         n_fail++;
         $display("FAIL walk_pulses: %0d upd pulses, required 15", pulses);
      end
      n_checks++;
      if (errs != 0) begin
         n_fail++;
         $display("FAIL walk_gray_err: %0d err pulses, required 0", errs);
      end
   endtask

   task automatic test_reset_mid_settle();
      int pulses;
      pulses = 0;
      bus.sw_i = 4'b1100;
      repeat (4) tick();
      n_checks++;
      if (bus.settling_o !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_settle_entry: settling=%b, required 1", bus.settling_o);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.s_o !== 4'b0000 || bus.settling_o !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_settle_async: s=%b settling=%b, required 0000 0", bus.s_o, bus.settling_o);
      end
      tick();
      rst_n = 1'b1;
      repeat (6) tick();
      n_checks++;
      if (bus.s_o !== 4'b0000 || bus.upd_o !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_settle_early: s=%b upd=%b after 6 edges, required 0000 0", bus.s_o, bus.upd_o);
      end
      tick();
      n_checks++;
      if (bus.s_o !== 4'b1100 || bus.upd_o !== 1'b1 || bus.gray_err_o !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_settle_commit: s=%b upd=%b err=%b after 7 edges, required 1100 1 1",
                  bus.s_o, bus.upd_o, bus.gray_err_o);
      end
      repeat (10) begin
         tick();
         if (bus.upd_o === 1'b1) pulses++;
      end
      n_checks++;
      if (pulses != 0 || bus.s_o !== 4'b1100) begin
         n_fail++;
         $display("FAIL mid_settle_single: extra pulses=%0d s=%b, required 0 1100", pulses, bus.s_o);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      bus.sw_i = 4'b0000;
      test_reset();
      test_single_change();
      test_bounce();
      test_restart();
      test_gray_walk();
      test_reset_mid_settle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
